// File: rtl/mul8x8_seq.sv
// rtl/mul8x8_seq.sv - sequential 8x8 unsigned multiplier time-sharing one 4x4 multiplier
// Four nibble partial products are accumulated into a 16-bit result over 4 (or 5) cycles.

module mul4x4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  assign p_o = {4'b0, a_i} * {4'b0, b_i};
endmodule

module mul8x8_seq #(
  parameter int PP_REG = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_p,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [2:0] LAST_STEP = (PP_REG != 0) ? 3'd4 : 3'd3;

  state_t      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [2:0]  step_q, step_d;
  logic [7:0]  pp_q;

  logic [3:0]  mul_a, mul_b;
  logic [7:0]  pp;
  logic [7:0]  pp_acc;
  logic [2:0]  sh_step;
  logic        acc_en;
  logic [15:0] addend;

  // step bit 0 picks the high nibble of a, bit 1 the high nibble of b
  assign mul_a = step_q[0] ? a_q[7:4] : a_q[3:0];
  assign mul_b = step_q[1] ? b_q[7:4] : b_q[3:0];

  mul4x4 u_mul4x4 (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (pp)
  );

  // With the product register, accumulation lags the multiplier by one step
  assign pp_acc  = (PP_REG != 0) ? pp_q : pp;
  assign sh_step = (PP_REG != 0) ? step_q - 3'd1 : step_q;
  assign acc_en  = (PP_REG != 0) ? (step_q != 3'd0) : 1'b1;

  always_comb begin
    addend = '0;
    case (sh_step)
      3'd0:       addend = {8'h00, pp_acc};
      3'd1, 3'd2: addend = {4'h0, pp_acc, 4'h0};
      default:    addend = {pp_acc, 8'h00};
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    step_d  = step_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          step_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (acc_en) acc_d = acc_q + addend;
        step_d = step_q + 3'd1;
        if (step_q == LAST_STEP) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      pp_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      pp_q    <= pp;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_p     = acc_q;

endmodule

// File: tb/tb_mul8x8_seq.sv
// tb/tb_mul8x8_seq.sv - random and directed checks of mul8x8_seq against a*b, both PP_REG settings
// Instance 0 uses PP_REG=0, instance 1 uses PP_REG=1.

module tb_mul8x8_seq;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        in_valid;
  logic [1:0]        out_ready;
  logic [1:0][7:0]   in_a;
  logic [1:0][7:0]   in_b;
  wire  [1:0]        in_ready;
  wire  [1:0]        out_valid;
  wire  [1:0]        busy;
  wire  [1:0][15:0]  out_p;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul8x8_seq #(.PP_REG(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_a(in_a[0]), .in_b(in_b[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_p(out_p[0]), .busy(busy[0])
  );

  mul8x8_seq #(.PP_REG(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_a(in_a[1]), .in_b(in_b[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_p(out_p[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // mode 0: drop in_valid after acceptance; 1: drive 0xFF operands during BUSY;
  // 2: keep in_valid high with 0x11*0x11 while the result is held
  task automatic do_txn(input int k, input logic [7:0] a, input logic [7:0] b,
                        input int mode, input int hold,
                        output logic [15:0] p, output int lat);
    int n;
    logic [15:0] exp_p;
    exp_p = 16'(a * b);
    p   = '0;
    lat = -1;
    in_valid[k] = 1'b1;
    in_a[k] = a;
    in_b[k] = b;
    n = 0;
    while (!in_ready[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[k]) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid[k] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    case (mode)
      1: begin in_valid[k] = 1'b0; in_a[k] = 8'hFF; in_b[k] = 8'hFF; end
      2: begin in_valid[k] = 1'b1; in_a[k] = 8'h11; in_b[k] = 8'h11; end
      default: in_valid[k] = 1'b0;
    endcase
    lat = 0;
    while (!out_valid[k] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid[k]) begin
      check("result_timeout", 32'd0, 32'd1);
      return;
    end
    p = out_p[k];
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_p", 32'(out_p[k]), 32'(exp_p));
      check("hold_valid", 32'(out_valid[k]), 32'd1);
      if (mode == 2) check("hold_in_ready", 32'(in_ready[k]), 32'd0);
    end
    out_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[k] = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p;
    int          lat;
    logic [7:0]  ca [3];
    logic [7:0]  cb [3];
    logic [15:0] cp [3];
    logic [7:0]  ra, rb;
    ca = '{8'hFF, 8'h00, 8'h80};
    cb = '{8'hFF, 8'hA5, 8'h02};
    cp = '{16'hFE01, 16'h0000, 16'h0100};

    rst = 1'b1;
    in_valid = '0;
    out_ready = '0;
    in_a = '0;
    in_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_in_ready", 32'(in_ready[k]), 32'd1);
      check("rst_out_valid", 32'(out_valid[k]), 32'd0);
      check("rst_out_p", 32'(out_p[k]), 32'd0);
      check("rst_busy", 32'(busy[k]), 32'd0);
    end

    do_txn(0, 8'h12, 8'h34, 0, 0, p, lat);
    check("p_12x34", 32'(p), 32'h03A8);
    check("lat_12x34", 32'(lat), 32'd4);

    for (int i = 0; i < 3; i++) begin
      do_txn(0, ca[i], cb[i], 0, 1, p, lat);
      check("p_corner", 32'(p), 32'(cp[i]));
    end

    do_txn(0, 8'h0F, 8'hF0, 2, 10, p, lat);
    check("p_0Fx F0", 32'(p), 32'h0E10);
    do_txn(0, 8'h11, 8'h11, 0, 0, p, lat);
    check("p_after_bp", 32'(p), 32'h0121);

    do_txn(0, 8'h12, 8'h34, 1, 0, p, lat);
    check("p_scrambled", 32'(p), 32'h03A8);

    in_valid[0] = 1'b1;
    in_a[0] = 8'hAB;
    in_b[0] = 8'hCD;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready[0]), 32'd1);
    check("midrst_busy", 32'(busy[0]), 32'd0);
    check("midrst_out_valid", 32'(out_valid[0]), 32'd0);
    check("midrst_out_p", 32'(out_p[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_result", 32'(out_valid[0]), 32'd0);
    end

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 2500; i++) begin
        ra = 8'($urandom);
        rb = 8'($urandom);
        if ($urandom_range(0, 15) == 0) ra = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        if ($urandom_range(0, 15) == 0) rb = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        do_txn(k, ra, rb, 0, int'($urandom_range(0, 2)), p, lat);
        check(k == 0 ? "rand_p_pp0" : "rand_p_pp1", 32'(p), 32'(ra * rb));
        check(k == 0 ? "rand_lat_pp0" : "rand_lat_pp1", 32'(lat), (k == 0) ? 32'd4 : 32'd5);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul8x8_seq.md
# mul8x8_seq

Sequential 8x8 unsigned multiplier controller. It time-shares one 4x4 unsigned multiplier instance (4-bit x 4-bit to 8-bit product, combinational) across four nibble partial products and accumulates them into a 16-bit result. It sits between a valid/ready operand source and a valid/ready result sink. It is the area-minimal alternative to a full 8x8 array.

## Interface

Parameters:
- PP_REG, default 0: 1 inserts a register on the 4x4 product before accumulation and adds 1 cycle of latency. Only 0 and 1 are legal.

Ports:
- clk, input, 1: sole clock; all state updates on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: operand pair present.
- in_ready, output, 1: block can accept operands.
- in_a, input, 8: multiplicand, unsigned.
- in_b, input, 8: multiplier, unsigned.
- out_valid, output, 1: result present.
- out_ready, input, 1: sink accepts result.
- out_p, output, 16: product in_a*in_b, unsigned.
- busy, output, 1: high in any state other than IDLE.

## Operation

- Exactly one 4x4 multiplier instance. No other multiply operator exists in the block.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_a/in_b into internal operand registers, clear the accumulator, set step=0, go to BUSY.
- BUSY:
  - in_ready=0. Input operands are ignored; the latched copies are used.
  - The step counter selects the multiplier operands and the shift:
    - step0: a[3:0]*b[3:0], shift 0
    - step1: a[7:4]*b[3:0], shift 4
    - step2: a[3:0]*b[7:4], shift 4
    - step3: a[7:4]*b[7:4], shift 8
  - PP_REG=0: on each edge, acc += zero-extended product << shift. After the step3 edge, go to DONE.
  - PP_REG=1:
    - The product register loads on each edge.
    - Accumulation uses the registered product and the shift of the previous step.
    - The step counter runs 0..4. Accumulation is enabled on steps 1..4.
    - After the step4 edge, go to DONE.
- DONE:
  - out_valid=1, and out_p=acc held stable.
  - On out_valid&&out_ready, go to IDLE.
- Arithmetic:
  - The accumulator is 16 bits. Partial products are zero-extended to 16 bits before shifting.
  - The maximum value 0xFF*0xFF=0xFE01 fits, so no overflow or truncation occurs at any step.
- out_p holds the last computed result in all states. It changes only as the accumulator updates during BUSY.
- rst asserted at any time, including mid-BUSY or in DONE with out_ready low:
  - Immediately forces IDLE.
  - acc, operand registers, product register and step go to 0.
  - The in-flight result is discarded, with no partial out_valid.

## Timing

- Reset values: in_ready=1, out_valid=0, out_p=0x0000, busy=0.
- Acceptance edge is E.
- PP_REG=0:
  - BUSY occupies edges E+1..E+4.
  - out_valid rises after E+4, a latency of 4 cycles.
- PP_REG=1:
  - BUSY occupies edges E+1..E+5.
  - Latency is 5 cycles.
- Minimum issue interval, with out_ready held high:
  - PP_REG=0: 6 cycles (1 IDLE + 4 BUSY + 1 DONE).
  - PP_REG=1: 7 cycles.
- Handshake rules:
  - in_ready and out_valid are functions of state only, with no combinational path from in_valid or out_ready.
  - out_valid, once high, stays high with out_p stable until out_ready is sampled high.
- in_valid may be held high continuously. Exactly one transaction is accepted per IDLE visit.

## Test plan

- Reset then idle, with PP_REG=0:
  - Stimulus: release rst.
  - Required: in_ready=1, out_valid=0, out_p=0x0000.
  - Then accept in_a=0x12, in_b=0x34. Required: out_valid after 4 cycles with out_p=0x03A8.
- Corner values:
  - Stimulus: 0xFF*0xFF, then 0x00*0xA5, then 0x80*0x02.
  - Required: out_p = 0xFE01, 0x0000, 0x0100 respectively.
- Backpressure:
  - Stimulus: after 0x0F*0xF0 completes, hold out_ready=0 for 10 cycles while in_valid=1 with in_a=0x11, in_b=0x11.
  - Required: out_p=0x0E10 stable, in_ready=0, new operands not accepted. The next result after release is 0x0121.
- Operand change mid-operation:
  - Stimulus: accept 0x12*0x34, then drive in_a/in_b to 0xFF during BUSY.
  - Required: result 0x03A8.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously at BUSY step2 of 0xAB*0xCD.
  - Required: immediately in_ready=1, busy=0, out_valid=0, out_p=0x0000. No result is emitted afterwards.
- Exhaustive, with PP_REG=0 and PP_REG=1:
  - Stimulus: all 65536 operand pairs back-to-back with random out_ready.
  - Required: every out_p equals a*b from a scoreboard.
  - Required latency: 4 cycles for PP_REG=0, 5 cycles for PP_REG=1.
